// File: rtl/inst_fetch_if.sv
// Instruction-memory bus between inst_fetch (master) and instruction memory (slave).
// One request is outstanding at a time; imem_rdata is valid with imem_ack while imem_req is high.
interface inst_fetch_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ack,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ack,
      output imem_rdata
   );
endinterface

// File: rtl/inst_fetch.sv
// inst_fetch: instruction fetch stage of the NIOS II-subset core, feeding ctrl_unit.
// Owns the PC, issues single-outstanding word requests, holds the presented word under
// stall and flushes on a branch redirect.
// Optional feature: define FETCH_BR_PREDECODE_EN to follow unconditional `br` words
// (opcode 6'b000110) at fetch time instead of waiting for branch_taken.
module inst_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                stall,
   input  logic                branch_taken,
   input  logic [31:0]         branch_target,
   inst_fetch_if.master        imem,
   output logic [31:0]         inst_out,
   output logic [31:0]         pc_out,
   output logic                inst_valid
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_HOLD  = 2'd2
   } state_t;

   // Both the reset PC and redirect targets are word addresses.
   localparam logic [31:0] RESET_PC_W = RESET_PC & ~32'h3;

   state_t      state;
   state_t      state_nxt;
   logic [31:0] pc;
   logic [31:0] pc_nxt;
   logic [31:0] inst_nxt;
   logic [31:0] pc_out_nxt;
   logic        valid_nxt;
   logic [31:0] target_w;
   logic [31:0] seq_pc;
   logic [31:0] fetch_pc;
   logic        ack_acc;
   logic        consume;

   assign target_w = branch_target & ~32'h3;
   assign seq_pc   = pc + 32'd4;

   // The request address is the PC register itself, so it cannot move while a request waits.
   assign imem.imem_addr = pc;
   assign imem.imem_req  = (state == S_FETCH) && !(inst_valid && stall);

   // An ack only counts while a request is actually being made.
   assign ack_acc = imem.imem_req && imem.imem_ack;
   assign consume = inst_valid && !stall;

   // Address of the word after the one being returned now.
`ifdef FETCH_BR_PREDECODE_EN
   logic        is_br;
   logic [31:0] br_offset;

   assign is_br     = (imem.imem_rdata[5:0] == 6'b000110);
   assign br_offset = {{16{imem.imem_rdata[21]}}, imem.imem_rdata[21:6]};
   assign fetch_pc  = is_br ? ((seq_pc + br_offset) & ~32'h3) : seq_pc;
`else
   assign fetch_pc  = seq_pc;
`endif

   // Next-state and next-output selection: redirect beats ack, ack beats consume.
   always_comb begin
      // NOTE: every target gets a hold value first so no path can infer a latch.
      state_nxt  = state;
      pc_nxt     = pc;
      inst_nxt   = inst_out;
      pc_out_nxt = pc_out;
      valid_nxt  = inst_valid;

      if (branch_taken) begin
         // Flush: any same-cycle ack data is dropped and the PC is not advanced.
         pc_nxt    = target_w;
         valid_nxt = 1'b0;
         state_nxt = S_FETCH;
      end else if (ack_acc) begin
         inst_nxt   = imem.imem_rdata;
         pc_out_nxt = pc;
         valid_nxt  = 1'b1;
         pc_nxt     = fetch_pc;
         state_nxt  = stall ? S_HOLD : S_FETCH;
      end else begin
         if (consume) begin
            valid_nxt = 1'b0;
         end
         case (state)
            S_IDLE:  state_nxt = S_FETCH;
            S_HOLD:  if (!stall) state_nxt = S_FETCH;
            default: state_nxt = state;
         endcase
      end
   end

   // State, PC and presented-instruction registers with synchronous active-low reset.
   always_ff @(posedge clock) begin
      // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
      if (!reset) begin
         state      <= S_IDLE;
         pc         <= RESET_PC_W;
         inst_out   <= 32'h0;
         pc_out     <= 32'h0;
         inst_valid <= 1'b0;
      end else begin
         state      <= state_nxt;
         pc         <= pc_nxt;
         inst_out   <= inst_nxt;
         pc_out     <= pc_out_nxt;
         inst_valid <= valid_nxt;
      end
   end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch stage of the NIOS II-subset core, sitting directly upstream of `ctrl_unit`. It owns the program counter and issues single-outstanding word requests to instruction memory. It presents each returned word on `inst_out` together with its address, and holds that word under downstream stall. On a redirect from the branch/execute logic it flushes, discarding any in-flight word.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded at reset. Bits [1:0] are ignored and treated as 0.
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low reset. `reset==0` at a rising edge resets the block.
- `stall`  in  1  downstream cannot accept a new instruction this cycle.
- `branch_taken`  in  1  one-cycle redirect request.
- `branch_target`  in  32  redirect address. Bits [1:0] are forced to 0.
- `imem_req`  out  1  fetch request; combinational from registered state.
- `imem_addr`  out  32  registered word address of the current request.
- `imem_ack`  in  1  memory returns `imem_rdata`. Valid only while `imem_req==1`; ignored otherwise.
- `imem_rdata`  in  32  instruction word, valid with `imem_ack`.
- `inst_out`  out  32  registered instruction presented to `ctrl_unit`.
- `pc_out`  out  32  registered address of `inst_out`.
- `inst_valid`  out  1  `inst_out` holds a live instruction.

## Operation
- States:
  - S_IDLE: post-reset, one cycle.
  - S_FETCH: requesting or awaiting ack.
  - S_HOLD: word held under stall, no request.
- `imem_req = (state==S_FETCH) && !(inst_valid && stall)`.
- Consume event: a rising edge with `inst_valid==1 && stall==0`.
- Event priority at each edge: reset, then `branch_taken`, then accepted ack (`imem_req && imem_ack`), then consume.
- Reset:
  - state=S_IDLE, pc=RESET_PC, imem_addr=RESET_PC.
  - inst_out=0, pc_out=0, inst_valid=0, imem_req=0.
  - Reset mid-request abandons that request. An ack arriving in the same cycle is ignored.
- S_IDLE: always moves to S_FETCH on the next edge.
- Accepted ack:
  - inst_out<=imem_rdata, pc_out<=pc, inst_valid<=1.
  - pc<=next_pc and imem_addr<=next_pc, where next_pc=pc+4 (mod 2^32; 32'hFFFF_FFFC wraps to 0).
  - If `stall==1` in that same cycle, go to S_HOLD; otherwise stay in S_FETCH.
- Consume with no accepted ack: inst_valid<=0.
- S_HOLD:
  - inst_out, pc_out and inst_valid are held.
  - When `stall==0`, the word is consumed and the block returns to S_FETCH. `imem_req` rises in the following cycle.
- `branch_taken`:
  - pc<=target, imem_addr<=target, inst_valid<=0, state<=S_FETCH.
  - Same-cycle ack data is discarded and pc is not advanced.
  - Overrides `stall` and S_HOLD.
- `stall` alone never alters pc or imem_addr.

## Timing
- First `imem_req` occurs 1 cycle after reset is released (the S_IDLE cycle).
- Zero-wait memory (ack in the same cycle as req): one instruction per cycle and `inst_valid` continuously high.
- N-cycle memory: `inst_valid` stays 0 for the intervening cycles once the previous word is consumed.
- Fetch-to-`inst_out` latency is 1 edge after the accepted ack.
- Redirect:
  - Target is on `imem_addr` 1 cycle after `branch_taken`.
  - Earliest valid target instruction is 2 cycles after `branch_taken` with zero-wait memory.
- At most one outstanding request. `imem_addr` is stable while `imem_req==1` until ack.

## Configuration
- `FETCH_BR_PREDECODE_EN` defined:
  - On an accepted ack whose `imem_rdata[5:0]==6'b000110` (`br`), next_pc = pc + 4 + sign-extend(`imem_rdata[21:6]`).
  - The fetched `br` word is still presented on `inst_out`.
  - A `branch_taken` in the same cycle still wins.
- Not defined: next_pc = pc + 4 always. Unconditional branches are resolved only through `branch_taken`.

## Test plan
- Reset: RESET_PC=0, hold `reset=0` for 3 cycles while `imem_ack=1` -> imem_req=0, inst_out=0, pc_out=0, inst_valid=0. After release: S_IDLE for 1 cycle, then imem_req=1 with imem_addr=0.
- Zero-wait stream: ack every cycle with words 0x0000_0014, 0x0000_003A, 0x0000_0004 -> inst_out follows one word per cycle, pc_out=0,4,8, inst_valid constant 1.
- Stall: `stall=1` while inst_out=0x0000_0014 at pc_out=0 -> imem_req=0 and outputs frozen for 4 cycles. After release: imem_addr=4 requested on the next cycle.
- Flush: request to 0x8 pending, `branch_taken=1` with target 0x43 and `imem_ack=1` in the same cycle -> the word for 0x8 never appears, imem_addr=0x40 next cycle, later pc_out=0x40.
- Wrap: RESET_PC=32'hFFFF_FFFC, zero-wait memory -> pc_out=0xFFFF_FFFC then 0x0000_0000.
- Predecode: at pc 0x100, word with [5:0]=000110 and [21:6]=0x0010 -> next imem_addr=0x114 with `FETCH_BR_PREDECODE_EN`, 0x104 without. With [21:6]=0xFFF8 -> next imem_addr=0xFC with the macro.
